// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b - bin_in one bit per clock, LSB first,
// under a three-state IDLE/RUN/DONE controller.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  // One-bit full-subtract cell on the current LSBs of the operand shifters.
  logic a_bit, b_bit, d_bit, br_next;
  assign a_bit   = a_sh_q[0];
  assign b_bit   = b_sh_q[0];
  assign d_bit   = a_bit ^ b_bit ^ br_q;
  assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {d_bit, res_q[WIDTH-1:1]};
        br_d   = br_next;
        cnt_d  = cnt_q + 1'b1;
        // The final bit lands directly in the output registers on the same edge.
        if (cnt_q == LAST_BIT) begin
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bout_d  = br_next;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and randomized checks for serial_sub_ctrl at WIDTH=8.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int checks;
  int failures;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .bout   (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents operands with start for one edge; returns at the falling edge after acceptance.
  task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv);
    @(negedge clk);
    a = av; b = bv; bin_in = binv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) until done is seen at a falling edge.
  task automatic wait_done(input int max_cycles, output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < max_cycles) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        cycles++;
      end
    end
  endtask

  task automatic test_reset();
    bit seen;
    int cyc;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin_in = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, bout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_async got busy=%b done=%b diff=%h bout=%b want 0/0/00/0", busy, done, diff, bout);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, diff, bout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_hold got busy=%b done=%b diff=%h bout=%b want 0/0/00/0", busy, done, diff, bout);
    end
    // Release with start already high: first edge must accept.
    rst_n = 1'b1; a = 8'h09; b = 8'h04; bin_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL first_accept got busy=%b want 1", busy);
    end
    wait_done(20, seen, cyc);
    checks++;
    if (!seen || diff !== 8'h05 || bout !== 1'b0) begin
      failures++;
      $display("FAIL first_op got seen=%0d diff=%h bout=%b want 1/05/0", seen, diff, bout);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    int busy_cnt;
    do_start(8'h05, 8'h03, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < W; i++) begin
      if (busy === 1'b1 && done === 1'b0) busy_cnt++;
      // Operands change after capture and must not matter.
      a = 8'hFF; b = 8'h00; bin_in = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (busy_cnt != W) begin
      failures++;
      $display("FAIL basic_busy_cycles got %0d want %0d", busy_cnt, W);
    end
    checks++;
    if ({busy, done, diff, bout} !== {1'b0, 1'b1, 8'h02, 1'b0}) begin
      failures++;
      $display("FAIL basic_done got busy=%b done=%b diff=%h bout=%b want 0/1/02/0", busy, done, diff, bout);
    end
    @(negedge clk);
    checks++;
    if ({busy, done, diff} !== {1'b0, 1'b0, 8'h02}) begin
      failures++;
      $display("FAIL basic_idle got busy=%b done=%b diff=%h want 0/0/02", busy, done, diff);
    end
  endtask

  task automatic test_borrow();
    bit seen;
    int cyc;
    int held_bad;
    do_start(8'h03, 8'h05, 1'b0);
    held_bad = 0;
    for (int i = 0; i < W; i++) begin
      if (diff !== 8'h02 || bout !== 1'b0) held_bad++;
      @(negedge clk);
    end
    checks++;
    if (held_bad != 0) begin
      failures++;
      $display("FAIL hold_during_run got %0d changed cycles want 0", held_bad);
    end
    wait_done(4, seen, cyc);
    checks++;
    if (!seen || diff !== 8'hFE || bout !== 1'b1) begin
      failures++;
      $display("FAIL borrow got seen=%0d diff=%h bout=%b want 1/fe/1", seen, diff, bout);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] av [6] = '{8'h00, 8'hFF, 8'h80, 8'h04, 8'hFF, 8'h00};
    logic [W-1:0] bv [6] = '{8'h00, 8'h00, 8'h7F, 8'h03, 8'hFF, 8'hFF};
    logic         cv [6] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
    logic [W-1:0] dx [6] = '{8'hFF, 8'hFE, 8'h01, 8'h00, 8'hFF, 8'h01};
    logic         bx [6] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
    bit seen;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      do_start(av[i], bv[i], cv[i]);
      wait_done(20, seen, cyc);
      checks++;
      if (!seen || cyc != W || diff !== dx[i] || bout !== bx[i]) begin
        failures++;
        $display("FAIL directed_%0d got seen=%0d lat=%0d diff=%h bout=%b want 1/%0d/%h/%b",
                 i, seen, cyc, diff, bout, W, dx[i], bx[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_held();
    bit seen;
    int cyc;
    @(negedge clk);
    a = 8'h10; b = 8'h01; bin_in = 1'b0; start = 1'b1;
    @(negedge clk);  // after E0
    for (int k = 1; k <= W; k++) begin
      a = 8'($urandom); b = 8'($urandom); bin_in = 1'($urandom);
      @(negedge clk);
    end
    // After E8: done with first result.
    checks++;
    if ({busy, done, diff, bout} !== {1'b0, 1'b1, 8'h0F, 1'b0}) begin
      failures++;
      $display("FAIL held_first got busy=%b done=%b diff=%h bout=%b want 0/1/0f/0", busy, done, diff, bout);
    end
    a = 8'h20; b = 8'h30; bin_in = 1'b0;
    @(negedge clk);  // after E9
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL held_e9 got busy=%b done=%b want 0/0", busy, done);
    end
    @(negedge clk);  // after E10
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL held_e10_accept got busy=%b want 1", busy);
    end
    wait_done(20, seen, cyc);
    checks++;
    if (!seen || diff !== 8'hF0 || bout !== 1'b1) begin
      failures++;
      $display("FAIL held_second got seen=%0d diff=%h bout=%b want 1/f0/1", seen, diff, bout);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    do_start(8'hAA, 8'h55, 1'b0);
    repeat (4) @(negedge clk);  // bits 0..3 processed
    checks++;
    if (busy !== 1'b1 || diff !== 8'hF0) begin
      failures++;
      $display("FAIL pre_abort got busy=%b diff=%h want 1/f0", busy, diff);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, bout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL abort_async got busy=%b done=%b diff=%h bout=%b want 0/0/00/0", busy, done, diff, bout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || diff !== 8'h00) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL abort_quiet got %0d active cycles want 0", done_seen);
    end
  endtask

  task automatic test_random();
    bit seen;
    int cyc;
    logic [W-1:0] av, bv;
    logic         cv;
    logic [W:0]   exp_v;
    for (int n = 0; n < 1000; n++) begin
      av = 8'($urandom); bv = 8'($urandom); cv = 1'($urandom);
      exp_v = {1'b0, av} - {1'b0, bv} - {8'h00, cv};
      do_start(av, bv, cv);
      wait_done(20, seen, cyc);
      checks++;
      if (!seen || {bout, diff} !== exp_v) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h bin=%b got seen=%0d bout=%b diff=%h want %b/%h",
                 n, av, bv, cv, seen, bout, diff, exp_v[W], exp_v[W-1:0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_directed();
    test_start_held();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
